// File: rtl/lc3_pkg.sv
// Shared types and default widths for the LC-3 memory-port arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package lc3_pkg;

  localparam int LC3_ADDR_W = 16;
  localparam int LC3_DATA_W = 16;

  // Who owns the memory port (last grant, or the read currently returning data)
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

endpackage

// File: rtl/lc3_arb_pick.sv
// Combinational winner selection between CPU and debug master.
// Latency: 0 cycles (pure combinational).
// Backpressure: a losing requester simply sees no winner for itself.
module lc3_arb_pick
  import lc3_pkg::*;
#(
  parameter int MAX_LOCK = 8
) (
  input  logic       cpu_req,
  input  logic       dbg_req,
  input  logic       dbg_lock,
  input  owner_t     last_owner,
  input  logic [7:0] lock_cnt,
  output owner_t     winner
);

  // Priority chain: lone requester, then bounded debug lock, then alternate owners
  always_comb begin
    winner = OWN_NONE;
    if (cpu_req && !dbg_req) begin
      winner = OWN_CPU;
    end else if (dbg_req && !cpu_req) begin
      winner = OWN_DBG;
    end else if (cpu_req && dbg_req) begin
      if (dbg_lock && (last_owner == OWN_DBG) && (lock_cnt < 8'(MAX_LOCK))) begin
        winner = OWN_DBG;
      end else if (last_owner == OWN_CPU) begin
        winner = OWN_DBG;
      end else begin
        // Covers last_owner == DBG (lock exhausted or off) and NONE (CPU first)
        winner = OWN_CPU;
      end
    end
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares one synchronous-read LC-3 memory port between CPU and debug master.
// Latency: grant same cycle as request; read data and rvalid one cycle after grant.
// Backpressure: a requester holds addr/we/wdata until it sees gnt; cpu_stall flags a waiting CPU.
module lc3_mem_arbiter
  import lc3_pkg::*;
#(
  parameter int ADDR_W   = LC3_ADDR_W,
  parameter int DATA_W   = LC3_DATA_W,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  input  logic              dbg_lock,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_t     last_owner;
  owner_t     rd_owner;
  logic [7:0] lock_cnt;
  owner_t     pick_winner;
  owner_t     win;
  logic       win_we;

  lc3_arb_pick #(
    .MAX_LOCK(MAX_LOCK)
  ) u_pick (
    .cpu_req   (cpu_req),
    .dbg_req   (dbg_req),
    .dbg_lock  (dbg_lock),
    .last_owner(last_owner),
    .lock_cnt  (lock_cnt),
    .winner    (pick_winner)
  );

  // Effective winner; reset suppresses every grant so nothing reaches memory
  always_comb begin
    win = reset ? OWN_NONE : pick_winner;
  end

  // Grant outputs, stall flag and memory-port mux (idle port parks on CPU inputs)
  always_comb begin
    cpu_gnt   = (win == OWN_CPU);
    dbg_gnt   = (win == OWN_DBG);
    cpu_stall = cpu_req & ~cpu_gnt;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    win_we    = 1'b0;
    if (win == OWN_DBG) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_we    = dbg_we;
      win_we    = dbg_we;
    end else if (win == OWN_CPU) begin
      mem_we    = cpu_we;
      win_we    = cpu_we;
    end
  end

  // Ownership history, lock run length and pending-read owner
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner <= OWN_NONE;
      lock_cnt   <= 8'd0;
      rd_owner   <= OWN_NONE;
    end else begin
      if (win != OWN_NONE) begin
        last_owner <= win;
      end
      if (!dbg_lock || (win == OWN_CPU)) begin
        lock_cnt <= 8'd0;
      end else if ((win == OWN_DBG) && (lock_cnt != 8'hFF)) begin
        lock_cnt <= lock_cnt + 8'd1;
      end
      rd_owner <= ((win != OWN_NONE) && !win_we) ? win : OWN_NONE;
    end
  end

  // Read return: rd_owner clears asynchronously, so a reset drops any pending rvalid
  always_comb begin
    cpu_rvalid = (rd_owner == OWN_CPU);
    dbg_rvalid = (rd_owner == OWN_DBG);
    rdata      = mem_rdata;
  end

endmodule
